// File: rtl/se_sram_burst_ctrl.sv
// se_sram_burst_ctrl
//   Burst controller in front of a 65536x8 single-port synchronous SRAM.
//   A request (start address, length-1, direction) is accepted in IDLE.
//   Write bursts stream wr_data straight onto the SRAM port, one byte per
//   wr handshake. Read bursts issue SRAM reads whenever a slot is free and
//   capture the returned bytes into a 2-entry FIFO that feeds the rd stream.
//   Addresses wrap modulo 2^16 inside a burst.
//
// Ports
//   sram_clock, reset          clock, synchronous active-high reset
//   req_*                      burst request handshake (valid/ready)
//   wr_valid/wr_ready/wr_data  write-data stream (input)
//   rd_valid/rd_ready/rd_data  read-data stream (output)
//   busy                       a burst is in progress
//   byte_count                 completed byte transfers (mod 2^16)
//   sram_*                     SRAM drive and read data return
//
// Build option
//   SE_SRAM_BURST_CTRL_STATS_EN : when defined, byte_count counts every wr and
//   rd transfer; otherwise byte_count is tied to zero and no counter exists.

module se_sram_burst_ctrl (
  input  logic        sram_clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_address,
  input  logic [7:0]  req_length,
  input  logic        req_read_not_write,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [7:0]  rd_data,
  output logic        busy,
  output logic [15:0] byte_count,
  output logic [15:0] sram_address,
  output logic [7:0]  sram_write_data,
  output logic        sram_write_enable,
  output logic        sram_read_not_write,
  output logic        sram_select,
  input  logic [7:0]  sram_data_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] addr;
  logic [15:0] addr_next;
  logic [8:0]  remaining;
  logic [8:0]  remaining_next;

  logic [7:0]  fifo_mem [2];
  logic        fifo_rd_ptr;
  logic        fifo_wr_ptr;
  logic [1:0]  fifo_count;
  logic        in_flight;

  logic        wr_xfer;
  logic        rd_xfer;
  logic        rd_issue;
  logic [1:0]  slots_used;

  assign rd_valid = (fifo_count != 2'd0);
  assign rd_data  = fifo_mem[fifo_rd_ptr];
  assign rd_xfer  = rd_valid && rd_ready;
  assign busy     = (state != ST_IDLE);

  // A byte leaving the FIFO this cycle frees its slot for a read issued in
  // the same cycle; without this credit a held-high rd_ready would only see
  // one byte every other cycle.
  assign slots_used = fifo_count + {1'b0, in_flight} - {1'b0, rd_xfer};

  always_comb begin
    state_next          = state;
    addr_next           = addr;
    remaining_next      = remaining;
    req_ready           = 1'b0;
    wr_ready            = 1'b0;
    wr_xfer             = 1'b0;
    rd_issue            = 1'b0;
    sram_select         = 1'b0;
    sram_write_enable   = 1'b0;
    sram_read_not_write = 1'b0;
    sram_address        = addr;
    sram_write_data     = wr_data;

    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_next      = req_address;
          remaining_next = {1'b0, req_length} + 9'd1;
          state_next     = req_read_not_write ? ST_READ : ST_WRITE;
        end
      end

      ST_WRITE: begin
        wr_ready          = 1'b1;
        wr_xfer           = wr_valid;
        sram_select       = wr_valid;
        sram_write_enable = wr_valid;
        if (wr_xfer) begin
          addr_next      = addr + 16'd1;
          remaining_next = remaining - 9'd1;
          if (remaining == 9'd1) begin
            state_next = ST_IDLE;
          end
        end
      end

      ST_READ: begin
        if ((remaining != 9'd0) && (slots_used < 2'd2)) begin
          rd_issue            = 1'b1;
          sram_select         = 1'b1;
          sram_read_not_write = 1'b1;
          addr_next           = addr + 16'd1;
          remaining_next      = remaining - 9'd1;
        end
        if ((remaining == 9'd0) && !in_flight && (fifo_count == 2'd0)) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sram_clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      addr        <= '0;
      remaining   <= '0;
      fifo_rd_ptr <= 1'b0;
      fifo_wr_ptr <= 1'b0;
      fifo_count  <= '0;
      in_flight   <= 1'b0;
    end else begin
      state     <= state_next;
      addr      <= addr_next;
      remaining <= remaining_next;
      in_flight <= rd_issue;
      if (in_flight) begin
        fifo_wr_ptr <= ~fifo_wr_ptr;
      end
      if (rd_xfer) begin
        fifo_rd_ptr <= ~fifo_rd_ptr;
      end
      fifo_count <= fifo_count + {1'b0, in_flight} - {1'b0, rd_xfer};
    end
  end

  // Storage only; occupancy and pointers above decide what is valid.
  always_ff @(posedge sram_clock) begin
    if (in_flight) begin
      fifo_mem[fifo_wr_ptr] <= sram_data_out;
    end
  end

`ifdef SE_SRAM_BURST_CTRL_STATS_EN
  logic [15:0] byte_count_q;

  always_ff @(posedge sram_clock) begin
    if (reset) begin
      byte_count_q <= '0;
    end else if (wr_xfer || rd_xfer) begin
      byte_count_q <= byte_count_q + 16'd1;
    end
  end

  assign byte_count = byte_count_q;
`else
  assign byte_count = '0;
`endif

endmodule

// File: tb/tb_se_sram_burst_ctrl.sv
// Testbench for se_sram_burst_ctrl: directed scenarios plus randomized bursts,
// checked by a scoreboard fed from a byte-array reference memory.

module tb_se_sram_burst_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_address;
  logic [7:0]  req_length;
  logic        req_read_not_write;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  rd_data;
  logic        busy;
  logic [15:0] byte_count;
  logic [15:0] sram_address;
  logic [7:0]  sram_write_data;
  logic        sram_write_enable;
  logic        sram_read_not_write;
  logic        sram_select;
  logic [7:0]  sram_data_out;

  se_sram_burst_ctrl dut (
    .sram_clock          (clk),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_address         (req_address),
    .req_length          (req_length),
    .req_read_not_write  (req_read_not_write),
    .wr_valid            (wr_valid),
    .wr_ready            (wr_ready),
    .wr_data             (wr_data),
    .rd_valid            (rd_valid),
    .rd_ready            (rd_ready),
    .rd_data             (rd_data),
    .busy                (busy),
    .byte_count          (byte_count),
    .sram_address        (sram_address),
    .sram_write_data     (sram_write_data),
    .sram_write_enable   (sram_write_enable),
    .sram_read_not_write (sram_read_not_write),
    .sram_select         (sram_select),
    .sram_data_out       (sram_data_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM device model
  logic [7:0] sram_mem [65536];
  always @(posedge clk) begin
    if (sram_select && sram_write_enable) sram_mem[sram_address] <= sram_write_data;
    if (sram_select && sram_read_not_write) sram_data_out <= sram_mem[sram_address];
  end

  // Reference model and scoreboard
  logic [7:0]  ref_mem [65536];
  logic [15:0] wq_addr [$];
  logic [7:0]  wq_data [$];
  logic [7:0]  rq_data [$];
  logic [7:0]  wd [256];
  int          checks = 0;
  int          errors = 0;
  int          issued = 0;
  int          delivered = 0;
  logic [15:0] exp_bc = '0;
  int          rd_mode = 0;
  int unsigned acc_cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] exp_byte_count();
`ifdef SE_SRAM_BURST_CTRL_STATS_EN
    return exp_bc;
`else
    return 16'd0;
`endif
  endfunction

  // Monitor: compares DUT transfers against the scoreboard queues
  initial begin
    logic [15:0] ea;
    logic [7:0]  ed;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (sram_select && sram_write_enable) begin
          if (wq_addr.size() == 0) begin
            chk("unexpected_sram_write", 1, 0);
          end else begin
            ea = wq_addr.pop_front();
            ed = wq_data.pop_front();
            chk("sram_write_addr", {16'd0, sram_address}, {16'd0, ea});
            chk("sram_write_data", {24'd0, sram_write_data}, {24'd0, ed});
          end
          exp_bc = exp_bc + 16'd1;
        end
        if (sram_select && sram_read_not_write) issued++;
        if (rd_valid && rd_ready) begin
          if (rq_data.size() == 0) begin
            chk("unexpected_rd_data", 1, 0);
          end else begin
            ed = rq_data.pop_front();
            chk("rd_data", {24'd0, rd_data}, {24'd0, ed});
          end
          delivered++;
          exp_bc = exp_bc + 16'd1;
        end
        if (sram_select && sram_read_not_write)
          chk("reads_outstanding_le2", ((issued - delivered) <= 2) ? 1 : 0, 1);
        if (!sram_select)
          chk("strobes_idle", {30'd0, sram_write_enable, sram_read_not_write}, 0);
        chk("req_ready_eq_not_busy", {31'd0, req_ready}, {31'd0, ~busy});
      end
    end
  end

  // rd_ready pattern driver: 0 = always 1, 1 = 1,0,0 repeating, 2 = random
  initial begin
    int unsigned phase = 0;
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rd_mode)
        0: rd_ready = 1'b1;
        1: rd_ready = (phase % 3 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      phase++;
    end
  end

  task automatic do_req(input logic rnw, input logic [15:0] a, input logic [7:0] len);
    logic hs = 1'b0;
    req_valid          = 1'b1;
    req_address        = a;
    req_length         = len;
    req_read_not_write = rnw;
    for (int t = 0; t < 200 && !hs; t++) begin
      @(negedge clk);
      hs = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    acc_cyc   = cyc;
    if (!hs) chk("req_accept_timeout", 0, 1);
  endtask

  // Fills wd[] (random unless preset), updates the reference, runs the stream.
  task automatic do_write(input logic [15:0] a, input int n, input bit cont, input bit preset);
    int  idx = 0;
    logic hs;
    for (int i = 0; i < n; i++) begin
      if (!preset) wd[i] = 8'($urandom);
      ref_mem[16'(a + 16'(i))] = wd[i];
      wq_addr.push_back(16'(a + 16'(i)));
      wq_data.push_back(wd[i]);
    end
    do_req(1'b0, a, 8'(n - 1));
    wr_valid = cont ? 1'b1 : 1'($urandom_range(0, 1));
    wr_data  = wd[0];
    for (int t = 0; t < 4000 && idx < n; t++) begin
      @(negedge clk);
      hs = wr_valid && wr_ready;
      @(posedge clk);
      #1;
      if (hs) idx++;
      if (idx < n && (hs || !wr_valid)) begin
        wr_valid = cont ? 1'b1 : 1'($urandom_range(0, 1));
        wr_data  = wd[idx];
      end
    end
    wr_valid = 1'b0;
    if (idx != n) chk("write_stream_timeout", idx, n);
  endtask

  task automatic push_read(input logic [15:0] a, input int n);
    for (int i = 0; i < n; i++) rq_data.push_back(ref_mem[16'(a + 16'(i))]);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int t = 0; t < 5000 && !done; t++) begin
      @(negedge clk);
      if (!busy && rq_data.size() == 0 && wq_addr.size() == 0) done = 1;
    end
    if (!done) chk("idle_timeout", 0, 1);
    chk("byte_count", {16'd0, byte_count}, {16'd0, exp_byte_count()});
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] last_wa = 16'h0000;
    int          n;
    reset = 1'b1; req_valid = 0; req_address = '0; req_length = '0;
    req_read_not_write = 0; wr_valid = 0; wr_data = '0;
    for (int i = 0; i < 65536; i++) begin
      sram_mem[i] = 8'h00;
      ref_mem[i]  = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_req_ready", {31'd0, req_ready}, 1);
    chk("reset_rd_valid", {31'd0, rd_valid}, 0);
    chk("reset_wr_ready", {31'd0, wr_ready}, 0);
    chk("reset_sram_select", {31'd0, sram_select}, 0);
    chk("reset_byte_count", {16'd0, byte_count}, 0);
    @(posedge clk); #1;

    // Write A1..A4 at 0x1000, continuous valid: idle 4 cycles after accept
    for (int i = 0; i < 4; i++) wd[i] = 8'hA1 + 8'(i);
    do_write(16'h1000, 4, 1'b1, 1'b1);
    @(negedge clk);
    chk("write4_idle", {31'd0, busy}, 0);
    chk("write4_duration", cyc - acc_cyc, 4);
    wait_idle();

    // Read back with rd_ready high: rd_valid from 2 cycles after accept, back to back
    rd_mode = 0;
    @(posedge clk); #1;
    push_read(16'h1000, 4);
    do_req(1'b1, 16'h1000, 8'd3);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("read4_rd_valid_c%0d", k), {31'd0, rd_valid}, (k >= 2) ? 1 : 0);
    end
    wait_idle();
    chk("byte_count_after_wr_rd", {16'd0, byte_count},
        {16'd0, exp_byte_count() == 16'd0 ? 16'd0 : 16'd8});

    // 8-byte read with rd_ready 1,0,0,...
    @(posedge clk); #1;
    do_write(16'h2000, 8, 1'b0, 1'b0);
    wait_idle();
    rd_mode = 1;
    @(posedge clk); #1;
    push_read(16'h2000, 8);
    do_req(1'b1, 16'h2000, 8'd7);
    wait_idle();

    // Wrap-around write and readback
    @(posedge clk); #1;
    do_write(16'hFFFE, 3, 1'b1, 1'b0);
    wait_idle();
    rd_mode = 2;
    @(posedge clk); #1;
    push_read(16'hFFFE, 3);
    do_req(1'b1, 16'hFFFE, 8'd2);
    wait_idle();

    // Reset on the 3rd cycle of a 16-byte read
    rd_mode = 0;
    @(posedge clk); #1;
    do_req(1'b1, 16'h0100, 8'd15);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rq_data.delete();
    issued = 0; delivered = 0; exp_bc = '0;
    chk("rst_mid_busy", {31'd0, busy}, 0);
    chk("rst_mid_rd_valid", {31'd0, rd_valid}, 0);
    chk("rst_mid_sram_select", {31'd0, sram_select}, 0);
    chk("rst_mid_req_ready", {31'd0, req_ready}, 1);
    chk("rst_mid_wr_ready", {31'd0, wr_ready}, 0);
    chk("rst_mid_byte_count", {16'd0, byte_count}, 0);
    @(negedge clk);
    chk("rst_mid_next_busy", {31'd0, busy}, 0);

    // Randomized bursts
    for (int b = 0; b < 40; b++) begin
      @(posedge clk); #1;
      n = ($urandom_range(0, 9) == 0) ? 256 : int'($urandom_range(1, 16));
      if ($urandom_range(0, 3) == 0) a = 16'hFFF0 + 16'($urandom_range(0, 15));
      else a = 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, n, 1'($urandom_range(0, 1)), 1'b0);
        last_wa = a;
      end else begin
        if ($urandom_range(0, 1) == 0) a = last_wa;
        rd_mode  = int'($urandom_range(0, 2));
        wr_valid = 1'b1;
        wr_data  = 8'($urandom);
        push_read(a, n);
        do_req(1'b1, a, 8'(n - 1));
      end
      wait_idle();
      wr_valid = 1'b0;
    end

    chk("write_queue_drained", wq_addr.size(), 0);
    chk("read_queue_drained", rq_data.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
